// File: rtl/dma_io_pkg.sv
// ----------------------------------------------------------------------------
// dma_io_pkg
//   Shared types for the DMA I/O responder slice.
//   - resp_state_e : responder FSM states. One-hot, matching the encoding the
//                    controller-side timing-and-control FSM uses.
//   - dir_e        : transfer direction as seen by the peripheral.
// ----------------------------------------------------------------------------
package dma_io_pkg;

   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      REQ   = 4'b0010,
      ACK   = 4'b0100,
      RECOV = 4'b1000
   } resp_state_e;

   typedef enum logic {
      DIR_DEV2MEM = 1'b0,   // device -> memory: controller does IOR + MEMW
      DIR_MEM2DEV = 1'b1    // memory -> device: controller does MEMR + IOW
   } dir_e;

endpackage

// File: rtl/dma_io_responder_if.sv
// ----------------------------------------------------------------------------
// dma_io_responder_if
//   System-side DMA channel signals between the controller and one
//   peripheral responder.
//   DREQ         responder -> controller, request service (active-high)
//   DACK         controller -> responder, acknowledge (active-high)
//   IOR_N/IOW_N  controller -> responder, I/O read / write strobes (active-low)
//   EOP_N        controller -> responder, end of process (active-low)
//   DB_IN        controller -> responder, bus data sampled on IOW_N
//   DB_OUT/DB_OE responder -> controller, bus data and its output enable
//   modport master : controller side
//   modport slave  : responder side
// ----------------------------------------------------------------------------
interface dma_io_responder_if #(
   parameter int DATA_W = 8
);
   logic              DREQ;
   logic              DACK;
   logic              IOR_N;
   logic              IOW_N;
   logic              EOP_N;
   logic [DATA_W-1:0] DB_IN;
   logic [DATA_W-1:0] DB_OUT;
   logic              DB_OE;

   modport master (
      input  DREQ, DB_OUT, DB_OE,
      output DACK, IOR_N, IOW_N, EOP_N, DB_IN
   );

   modport slave (
      output DREQ, DB_OUT, DB_OE,
      input  DACK, IOR_N, IOW_N, EOP_N, DB_IN
   );
endinterface

// File: rtl/dma_io_fifo.sv
// ----------------------------------------------------------------------------
// dma_io_fifo
//   Synchronous FIFO buffering bytes between the device stream and the bus.
//   clk, rst_n  : clock, asynchronous active-low reset (contents discarded)
//   push/push_data : write one entry at the clock edge
//   pop         : remove the head entry at the clock edge
//   head        : current head entry (valid while !empty)
//   full/empty/count : occupancy; count is log2(FIFO_DEPTH)+1 bits
//   The caller never pushes when full nor pops when empty; the FIFO does not
//   guard against it. Push and pop in the same cycle leave count unchanged.
// ----------------------------------------------------------------------------
module dma_io_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  logic [DATA_W-1:0]             push_data,
   input  logic                          pop,
   output logic [DATA_W-1:0]             head,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q,  count_d;

   // Pointers wrap naturally because FIFO_DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is readable.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_data;
   end

   assign head  = mem_q[rd_ptr_q];
   assign full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/dma_io_responder.sv
// ----------------------------------------------------------------------------
// dma_io_responder
//   Peripheral-side endpoint of the single-transfer DREQ/DACK handshake.
//   Buffers bytes between a local device stream and the system data bus.
//   CLK, RESET_N    : clock, asynchronous active-low reset
//   bus             : controller-facing signals (dma_io_responder_if.slave)
//   enable          : arms the channel on its rising edge; 0 disarms
//   dir             : 0 device->memory, 1 memory->device (latched when idle
//                     and empty)
//   dev_in_*        : device source stream, used in device->memory
//   dev_out_*       : device sink stream, used in memory->device
//   tc_done         : one-cycle pulse when EOP_N is sampled low in service
//   proto_err       : one-cycle pulse on a protocol violation
//   dbg_state       : current responder FSM state
//   dbg_count       : current FIFO occupancy
//
//   Stream handshakes: a beat transfers at the rising CLK edge where valid and
//   ready are both high; valid never depends on ready; ready here depends only
//   on registered state (direction and FIFO occupancy).
// ----------------------------------------------------------------------------
module dma_io_responder
   import dma_io_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        CLK,
   input  logic                        RESET_N,
   dma_io_responder_if.slave           bus,
   input  logic                        enable,
   input  logic                        dir,
   input  logic                        dev_in_valid,
   output logic                        dev_in_ready,
   input  logic [DATA_W-1:0]           dev_in_data,
   output logic                        dev_out_valid,
   input  logic                        dev_out_ready,
   output logic [DATA_W-1:0]           dev_out_data,
   output logic                        tc_done,
   output logic                        proto_err,
   output resp_state_e                 dbg_state,
   output logic [$clog2(FIFO_DEPTH):0] dbg_count
);

   resp_state_e       state_q, state_d;
   dir_e              dir_q,   dir_d;
   logic              dreq_q,  dreq_d;
   logic              armed_q, armed_d;
   logic              en_q;
   logic              tc_q,    tc_d;
   logic              perr_q,  perr_d;

   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [DATA_W-1:0] fifo_head, fifo_push_data;

   // A floating strobe (1'bz) must read as deasserted, so only a solid 0
   // counts as active.
   logic ior_low, iow_low, eop;
   assign ior_low = (bus.IOR_N === 1'b0);
   assign iow_low = (bus.IOW_N === 1'b0);
   assign eop     = (bus.EOP_N === 1'b0);

   logic dev2mem, in_ack, rd_strobe, wr_strobe, wrong_strobe, service_cond;
   assign dev2mem      = (dir_q == DIR_DEV2MEM);
   assign in_ack       = (state_q == ACK) && bus.DACK;
   assign rd_strobe    = in_ack &&  dev2mem && ior_low;
   assign wr_strobe    = in_ack && !dev2mem && iow_low;
   assign wrong_strobe = in_ack && ((dev2mem && iow_low) || (!dev2mem && ior_low));
   assign service_cond = armed_q && ((dev2mem && !fifo_empty) || (!dev2mem && !fifo_full));

   // Device streams run in every state, concurrently with bus service.
   assign dev_in_ready  =  dev2mem && !fifo_full;
   assign dev_out_valid = !dev2mem && !fifo_empty;
   assign dev_out_data  = fifo_head;

   assign fifo_push      = (dev2mem && dev_in_valid && dev_in_ready) || wr_strobe;
   assign fifo_pop       = rd_strobe || (!dev2mem && dev_out_valid && dev_out_ready);
   assign fifo_push_data = dev2mem ? dev_in_data : bus.DB_IN;

   dma_io_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (CLK),
      .rst_n     (RESET_N),
      .push      (fifo_push),
      .push_data (fifo_push_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (dbg_count)
   );

   // Bus drive is combinational so data appears within the IOR_N cycle;
   // it is derived from state_q, so async reset removes it at once.
   assign bus.DB_OE  = rd_strobe;
   assign bus.DB_OUT = rd_strobe ? fifo_head : '0;
   assign bus.DREQ   = dreq_q;

   assign tc_done   = tc_q;
   assign proto_err = perr_q;
   assign dbg_state = state_q;

   // Next-state / registered-output logic.
   always_comb begin
      state_d = state_q;
      dreq_d  = dreq_q;
      tc_d    = 1'b0;
      perr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            dreq_d = 1'b0;
            if (service_cond) begin
               state_d = REQ;
               dreq_d  = 1'b1;
            end
         end
         REQ: begin
            dreq_d = 1'b1;
            if (eop) begin
               state_d = IDLE;
               dreq_d  = 1'b0;
               tc_d    = 1'b1;
            end else if (bus.DACK) begin
               state_d = ACK;
            end else if (!service_cond) begin
               state_d = IDLE;
               dreq_d  = 1'b0;
            end
         end
         ACK: begin
            dreq_d = 1'b1;
            // A strobe coinciding with EOP_N still moves its byte
            // (fifo_push/fifo_pop are independent of this branch).
            if (eop) begin
               state_d = IDLE;
               dreq_d  = 1'b0;
               tc_d    = 1'b1;
            end else if (!bus.DACK) begin
               state_d = IDLE;
               dreq_d  = 1'b0;
               perr_d  = 1'b1;
            end else if (rd_strobe || wr_strobe) begin
               state_d = RECOV;
               dreq_d  = 1'b0;
            end else if (wrong_strobe) begin
               perr_d  = 1'b1;
            end
         end
         RECOV: begin
            dreq_d = 1'b0;
            if (eop) begin
               state_d = IDLE;
               tc_d    = 1'b1;
            end else if (!bus.DACK) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            dreq_d  = 1'b0;
         end
      endcase
   end

   // Termination disarms in the same edge that samples EOP_N, so IDLE does
   // not re-request before software re-arms with a fresh enable edge.
   always_comb begin
      armed_d = armed_q;
      if (!enable)
         armed_d = 1'b0;
      else if (eop && (state_q != IDLE))
         armed_d = 1'b0;
      else if (!en_q)
         armed_d = 1'b1;
   end

   // Direction may only change when no byte of the old direction is buffered.
   always_comb begin
      dir_d = dir_q;
      if ((state_q == IDLE) && fifo_empty) dir_d = dir_e'(dir);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         dreq_q  <= 1'b0;
         tc_q    <= 1'b0;
         perr_q  <= 1'b0;
         armed_q <= 1'b0;
         en_q    <= 1'b0;
         dir_q   <= DIR_DEV2MEM;
      end else begin
         state_q <= state_d;
         dreq_q  <= dreq_d;
         tc_q    <= tc_d;
         perr_q  <= perr_d;
         armed_q <= armed_d;
         en_q    <= enable;
         dir_q   <= dir_d;
      end
   end

endmodule

// File: doc/dma_io_responder.md
Name: dma_io_responder

Overview:
- Peripheral-side endpoint of the DMA DREQ/DACK handshake. It requests service with DREQ and answers the DMA controller's DACK, IOR_N, IOW_N and EOP_N strobes.
- It buffers data between a local device stream interface and the system data bus.
- One instance sits on each DMA channel of a peripheral, opposite the controller's timing-and-control block.
- Single-transfer mode only: one DREQ/DACK cycle per byte.

Parameters:
- DATA_W, 8, data bus and FIFO word width
- FIFO_DEPTH, 4, buffer entries; power of 2, minimum 2

Ports:
- CLK  input  1  system clock
- RESET_N  input  1  asynchronous active-low reset
- DREQ  output  1  DMA request to the controller; active-high
- DACK  input  1  this channel's DMA acknowledge; active-high
- IOR_N  input  1  I/O read strobe; active-low; 1'bz is treated as deasserted
- IOW_N  input  1  I/O write strobe; active-low; 1'bz is treated as deasserted
- EOP_N  input  1  end-of-process from the controller; active-low
- DB_IN  input  DATA_W  system data bus, sampled on IOW_N
- DB_OUT  output  DATA_W  data driven to the system bus on IOR_N
- DB_OE  output  1  DB_OUT output enable; the top level tri-states the bus with it
- enable  input  1  arms the channel
- dir  input  1  0 = device-to-memory (controller does IOR+MEMW); 1 = memory-to-device (IOW+MEMR)
- dev_in_valid / dev_in_ready / dev_in_data  in/out/in  1/1/DATA_W  device source stream (dir=0)
- dev_out_valid / dev_out_ready / dev_out_data  out/in/out  1/1/DATA_W  device sink stream (dir=1)
- tc_done  output  1  one-cycle pulse when EOP_N is sampled low during service
- proto_err  output  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset values (async, RESET_N low): state IDLE, FIFO empty, DREQ=0, DB_OE=0, DB_OUT=0, tc_done=0, proto_err=0, armed=0, dir_q=0.
- armed: set on the rising edge of enable. Cleared on tc_done and whenever enable=0.
- dir_q: latches dir only when state=IDLE and the FIFO is empty. Otherwise the previous direction holds.
- Stream ports:
  - dev_in_ready = (dir_q==0) & !full
  - dev_out_valid = (dir_q==1) & !empty
  - dev_out_data = FIFO head
  - Streams keep operating in every state, including while DMA service is in progress.
- FSM states: IDLE, REQ, ACK, RECOV.
- IDLE:
  - Move to REQ when armed & ((dir_q==0 & !empty) | (dir_q==1 & !full)).
  - DREQ is registered: it goes high the cycle after the condition is true.
- REQ:
  - DREQ=1.
  - DACK=1 -> ACK.
  - Condition becomes false (device drained or filled the FIFO) -> IDLE, DREQ drops.
- ACK:
  - DREQ stays 1 until the strobe cycle.
  - dir_q=0, IOR_N low: DB_OE=1 and DB_OUT=FIFO head, combinationally in that cycle. Pop at the clock edge ending the cycle. -> RECOV.
  - dir_q=1, IOW_N low: push DB_IN at the clock edge. -> RECOV.
  - Wrong-direction strobe (IOW_N in dir 0, IOR_N in dir 1): no data movement, proto_err pulse, remain in ACK.
  - DACK drops before any strobe: proto_err pulse, -> IDLE, no transfer.
- RECOV:
  - DREQ=0.
  - Wait for DACK=0, then -> IDLE. This guarantees at least one dead cycle between requests.
- DB_OE is 1 only in ACK & DACK & !IOR_N & dir_q==0. It is never asserted in any other case.
- EOP_N low sampled in REQ, ACK or RECOV:
  - tc_done pulse, armed cleared, -> IDLE, DREQ=0 next cycle.
  - If a strobe coincides with EOP_N in ACK, the transfer still completes (pop/push) before termination.
  - EOP_N in IDLE is ignored.
- Simultaneous FIFO push and pop in the same cycle (device and bus) is legal; the count is unchanged.
- Full FIFO in dir 1: no request is issued.
- Empty FIFO in dir 0: no request is issued.
- A push to a full FIFO or a pop from an empty FIFO is impossible by construction. The bench asserts this never happens.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits.
- RESET_N asserted mid-transfer: everything returns to reset values immediately, including DREQ=0 and DB_OE=0 asynchronously. FIFO contents are discarded.

Decomposition:
- Package dma_io_pkg holds:
  - responder state enum (IDLE, REQ, ACK, RECOV), one-hot encoded like the controller FSM
  - dir typedef with DIR_DEV2MEM=0, DIR_MEM2DEV=1
- Sub-module dma_io_fifo: synchronous FIFO with push/pop/full/empty/count, async active-low reset, parameterized by DATA_W and FIFO_DEPTH.

Test Plan:
- Device-to-memory single byte:
  - Stimulus: dir=0, enable rises, device pushes 0xA5; controller model gives DACK 2 cycles after DREQ, then IOR_N low for 1 cycle.
  - Response: DREQ=1 one cycle after the push; DB_OE=1 with DB_OUT=0xA5 only in the IOR_N cycle; FIFO empty afterwards; DREQ=0 until DACK falls.
- Memory-to-device burst:
  - Stimulus: dir=1, dev_out_ready=0; controller writes 0x11, 0x22, 0x33, 0x44 via IOW_N.
  - Response: DREQ stops after the 4th write (FIFO full); device then reads 0x11..0x44 in order.
- Terminal count:
  - Stimulus: EOP_N low together with the 3rd IOR_N strobe.
  - Response: 3rd byte popped, tc_done pulses once, DREQ=0; no new DREQ until enable toggles 0->1.
- Protocol error:
  - Stimulus: dir=0, IOW_N strobe during ACK, then DACK drops with no strobe.
  - Response: two proto_err pulses, FIFO count unchanged, state IDLE, then re-request.
- Async reset:
  - Stimulus: RESET_N low while DB_OE=1 in ACK.
  - Response: DB_OE, DREQ and FIFO count are 0 immediately; no spurious tc_done after release.
- Wrap-around:
  - Stimulus: 10 bytes streamed dir=0 with concurrent device push and DMA pop.
  - Response: bytes arrive in order on DB_OUT, no loss across pointer wrap.
